// File: rtl/ref_stream_loader.sv
// rtl/ref_stream_loader.sv - AXIS reference loader: header N, N samples + zero pad into ref FIFO, load_cmd to ping-pong memory.
// Optional REF_LOADER_STATS_EN adds stat_frames / stat_words counters.
module ref_stream_loader #(
  parameter int AXIS_WIDTH       = 32,
  parameter int REFMEM_PTR_WIDTH = 15,
  parameter int PAD_WORDS        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AXIS_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic                  fifo_wr_en,
  output logic [AXIS_WIDTH-1:0] fifo_din,
  input  logic                  fifo_full,
  input  logic                  fifo_clear,
  input  logic                  mem_busy,
  input  logic                  ref_load_done,
  output logic                  load_cmd,
  output logic [AXIS_WIDTH-1:0] ref_len,
  output logic                  loader_busy,
  output logic [2:0]            err_flags
`ifdef REF_LOADER_STATS_EN
  ,
  output logic [31:0]           stat_frames,
  output logic [31:0]           stat_words
`endif
);

  localparam int CNT_W = REFMEM_PTR_WIDTH + 1;
  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(2**REFMEM_PTR_WIDTH - PAD_WORDS);
  localparam logic [CNT_W-1:0] PAD_N = CNT_W'(PAD_WORDS);
  localparam logic [CNT_W-1:0] ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE, HDR, CMD, WAIT_CLR, STREAM, PAD, DRAIN, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_seen_q, last_seen_d;
  logic             long_q, long_d;
  logic             bad_q, bad_d;
  logic [2:0]       err_q, err_d;

  logic [CNT_W-1:0] hdr_n;
  logic             hdr_bad;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] pad_end;
  logic             can_write;

  assign hdr_n     = s_axis_tdata[REFMEM_PTR_WIDTH:0];
  assign hdr_bad   = (hdr_n == '0) || (hdr_n > MAX_N);
  assign cnt_inc   = cnt_q + ONE;
  // cnt keeps counting through PAD, so the frame ends at N + PAD_WORDS writes.
  assign pad_end   = len_q + PAD_N;
  assign can_write = !fifo_full && !fifo_clear;

  assign ref_len     = {{(AXIS_WIDTH-CNT_W){1'b0}}, len_q};
  assign loader_busy = (state_q != IDLE);
  assign err_flags   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      last_seen_q <= 1'b0;
      long_q      <= 1'b0;
      bad_q       <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      last_seen_q <= last_seen_d;
      long_q      <= long_d;
      bad_q       <= bad_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    last_seen_d   = last_seen_q;
    long_d        = long_q;
    bad_d         = bad_q;
    err_d         = err_q;
    s_axis_tready = 1'b0;
    fifo_wr_en    = 1'b0;
    fifo_din      = '0;
    load_cmd      = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_axis_tvalid) state_d = HDR;
      end

      HDR: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          if (hdr_bad) begin
            err_d[0] = 1'b1;
            bad_d    = 1'b1;
            state_d  = s_axis_tlast ? IDLE : DRAIN;
          end else begin
            len_d       = hdr_n;
            cnt_d       = '0;
            long_d      = 1'b0;
            bad_d       = 1'b0;
            // A frame that ends on its header gets all N words as zeros.
            last_seen_d = s_axis_tlast;
            if (s_axis_tlast) err_d[1] = 1'b1;
            state_d     = CMD;
          end
        end
      end

      CMD: begin
        if (!mem_busy) begin
          load_cmd = 1'b1;
          state_d  = WAIT_CLR;
        end
      end

      WAIT_CLR: begin
        if (!fifo_clear) state_d = last_seen_q ? PAD : STREAM;
      end

      STREAM: begin
        s_axis_tready = can_write;
        if (s_axis_tvalid && can_write) begin
          fifo_wr_en = 1'b1;
          fifo_din   = s_axis_tdata;
          cnt_d      = cnt_inc;
          if (cnt_inc == len_q) begin
            if (!s_axis_tlast) begin
              err_d[2] = 1'b1;
              long_d   = 1'b1;
            end
            state_d = PAD;
          end else if (s_axis_tlast) begin
            err_d[1] = 1'b1;
            state_d  = PAD;
          end
        end
      end

      PAD: begin
        if (can_write) begin
          fifo_wr_en = 1'b1;
          cnt_d      = cnt_inc;
          if (cnt_inc == pad_end) state_d = long_q ? DRAIN : DONE;
        end
      end

      DRAIN: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_d = bad_q ? IDLE : DONE;
      end

      DONE: begin
        if (ref_load_done) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

`ifdef REF_LOADER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_frames <= '0;
      stat_words  <= '0;
    end else begin
      if (state_q == DONE && ref_load_done) stat_frames <= stat_frames + 32'd1;
      if (state_q == STREAM && fifo_wr_en)  stat_words  <= stat_words + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ref_stream_loader.sv
// tb/tb_ref_stream_loader.sv - directed bench for ref_stream_loader with a FIFO-write scoreboard.
module tb_ref_stream_loader;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] s_axis_tdata = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic         s_axis_tlast = 1'b0;
  logic         fifo_wr_en;
  logic [W-1:0] fifo_din;
  logic         fifo_full = 1'b0;
  logic         fifo_clear = 1'b1;
  logic         mem_busy = 1'b0;
  logic         ref_load_done = 1'b0;
  logic         load_cmd;
  logic [W-1:0] ref_len;
  logic         loader_busy;
  logic [2:0]   err_flags;
`ifdef REF_LOADER_STATS_EN
  logic [31:0]  stat_frames;
  logic [31:0]  stat_words;
`endif

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int load_pulses = 0;
  logic [W-1:0] exp_q[$];

  ref_stream_loader dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_din      (fifo_din),
    .fifo_full     (fifo_full),
    .fifo_clear    (fifo_clear),
    .mem_busy      (mem_busy),
    .ref_load_done (ref_load_done),
    .load_cmd      (load_cmd),
    .ref_len       (ref_len),
    .loader_busy   (loader_busy),
    .err_flags     (err_flags)
`ifdef REF_LOADER_STATS_EN
    ,
    .stat_frames   (stat_frames),
    .stat_words    (stat_words)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] d);
    exp_q.push_back(d);
  endtask

  // FIFO-side scoreboard: every write must match the next expected word and never land during clear.
  always @(negedge clk) begin
    if (!rst) begin
      if (load_cmd) load_pulses++;
      if (fifo_wr_en) begin
        wr_count++;
        check("wr_during_clear", fifo_clear, 1'b0);
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL extra_write observed=%0h expected=none", fifo_din);
        end
        if (exp_q.size() > 0) check("fifo_din", fifo_din, exp_q.pop_front());
      end
    end
  end

  task automatic send_beat(input logic [W-1:0] d, input logic last);
    int t = 0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    @(negedge clk);
    while (!s_axis_tready && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("beat_accepted", s_axis_tready, 1'b1);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_load(input logic [W-1:0] len);
    int t = 0;
    @(negedge clk);
    while (!load_cmd && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("load_cmd_seen", load_cmd, 1'b1);
    check("ref_len", ref_len, len);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    fifo_clear = 1'b0;
  endtask

  task automatic finish_frame(input int exp_writes, input int exp_loads);
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("writes_pending", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check("write_count", wr_count, exp_writes);
    check("load_pulses", load_pulses, exp_loads);
    check("busy_in_done", loader_busy, 1'b1);
    @(posedge clk);
    #1;
    ref_load_done = 1'b1;
    t = 0;
    @(negedge clk);
    while (loader_busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    ref_load_done = 1'b0;
    fifo_clear    = 1'b1;
    @(negedge clk);
    check("back_to_idle", loader_busy, 1'b0);
    wr_count    = 0;
    load_pulses = 0;
  endtask

  initial begin
    int viol;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_tready", s_axis_tready, 1'b0);
    check("rst_wr_en", fifo_wr_en, 1'b0);
    check("rst_load_cmd", load_cmd, 1'b0);
    check("rst_ref_len", ref_len, 0);
    check("rst_busy", loader_busy, 1'b0);
    check("rst_err", err_flags, 3'b000);

    // Nominal frame of 5 samples.
    for (int i = 1; i <= 5; i++) push(i);
    push(0); push(0);
    send_beat(5, 1'b0);
    wait_load(5);
    for (int i = 1; i <= 5; i++) send_beat(i, i == 5);
    finish_frame(7, 1);
    check("err_nominal", err_flags, 3'b000);

    // Memory busy holds off the load request.
    for (int i = 1; i <= 4; i++) push(32'h100 + i);
    push(0); push(0);
    mem_busy = 1'b1;
    send_beat(4, 1'b0);
    viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (s_axis_tready || load_cmd) viol++;
    end
    check("busy_wait_quiet", viol, 0);
    @(posedge clk);
    #1 mem_busy = 1'b0;
    wait_load(4);
    for (int i = 1; i <= 4; i++) send_beat(32'h100 + i, i == 4);
    finish_frame(6, 1);
    check("err_busy", err_flags, 3'b000);

    // Short frame: 3 of 6 samples, then 3 fill zeros and 2 pads.
    for (int i = 1; i <= 3; i++) push(32'h200 + i);
    for (int i = 0; i < 5; i++) push(0);
    send_beat(6, 1'b0);
    wait_load(6);
    for (int i = 1; i <= 3; i++) send_beat(32'h200 + i, i == 3);
    finish_frame(8, 1);
    check("err_short", err_flags, 3'b010);

    // Long frame: 2 samples kept, beats 3-4 drained.
    push(32'h301); push(32'h302); push(0); push(0);
    send_beat(2, 1'b0);
    wait_load(2);
    for (int i = 1; i <= 4; i++) send_beat(32'h300 + i, i == 4);
    finish_frame(4, 1);
    check("err_long", err_flags, 3'b110);

    // Zero-length header: whole frame discarded.
    send_beat(0, 1'b0);
    for (int i = 1; i <= 3; i++) send_beat(32'h400 + i, i == 3);
    repeat (3) @(negedge clk);
    check("badlen_idle", loader_busy, 1'b0);
    check("badlen_no_load", load_pulses, 0);
    check("badlen_no_write", wr_count, 0);
    check("err_badlen", err_flags, 3'b111);

    // Upper header bits ignored; fifo_full stall mid-stream.
    push(32'h501); push(32'h502); push(32'h503); push(0); push(0);
    send_beat(32'h5A5A_0003, 1'b0);
    wait_load(3);
    send_beat(32'h501, 1'b0);
    fifo_full     = 1'b1;
    s_axis_tdata  = 32'h502;
    s_axis_tvalid = 1'b1;
    viol = 0;
    repeat (4) begin
      @(negedge clk);
      if (s_axis_tready || fifo_wr_en) viol++;
    end
    check("full_stall", viol, 0);
    @(posedge clk);
    #1 fifo_full = 1'b0;
    send_beat(32'h502, 1'b0);
    send_beat(32'h503, 1'b1);
    finish_frame(5, 1);

    // One past the legal maximum, tlast on header: straight back to idle.
    send_beat(32'h0000_7FFF, 1'b1);
    repeat (2) @(negedge clk);
    check("over_max_idle", loader_busy, 1'b0);
    check("over_max_no_load", load_pulses, 0);
    check("over_max_no_write", wr_count, 0);

    // Legal header carrying tlast: all N words zero-filled.
    for (int i = 0; i < 4; i++) push(0);
    send_beat(2, 1'b1);
    wait_load(2);
    finish_frame(4, 1);
    check("err_final", err_flags, 3'b111);

`ifdef REF_LOADER_STATS_EN
    check("stat_frames", stat_frames, 6);
    check("stat_words", stat_words, 17);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ref_stream_loader.md
Name: ref_stream_loader

Overview:
- Producer side of the reference-memory load path.
- Accepts a reference sequence on an AXI-Stream slave: header beat = sample count N, then N sample beats.
- Issues load_cmd/ref_len to the ping-pong reference memory and writes the N samples plus PAD_WORDS zero pad words into the source FIFO that the memory drains.
- Sits between the DMA/AXIS ingress and the reference FIFO feeding the ping-pong memory.

Parameters:
- AXIS_WIDTH, 32, AXI-Stream and FIFO data width.
- REFMEM_PTR_WIDTH, 15, reference memory address width; legal N is 1 .. 2^REFMEM_PTR_WIDTH - PAD_WORDS.
- PAD_WORDS, 2, zero words appended after the N samples.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- s_axis_tdata  in  AXIS_WIDTH  header (N) or sample in bits [15:0].
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  beat accepted when tvalid&tready.
- s_axis_tlast  in  1  last beat of frame.
- fifo_wr_en  out  1  source FIFO write strobe.
- fifo_din  out  AXIS_WIDTH  source FIFO write data.
- fifo_full  in  1  source FIFO full.
- fifo_clear  in  1  FIFO clear from memory; high while the memory is idle.
- mem_busy  in  1  both ping-pong buffers occupied.
- ref_load_done  in  1  a buffer holds a complete load.
- load_cmd  out  1  one-cycle load request.
- ref_len  out  AXIS_WIDTH  N, held stable from load_cmd until return to IDLE.
- loader_busy  out  1  state != IDLE.
- err_flags  out  3  sticky: [0] bad length, [1] short frame, [2] long frame.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0. Reset mid-frame aborts immediately; no further FIFO writes.
- States: IDLE, HDR, CMD, WAIT_CLR, STREAM, PAD, DRAIN, DONE.
- IDLE:
  - tready=0.
  - Go to HDR when tvalid=1.
- HDR:
  - tready=1.
  - On accept, N = tdata[REFMEM_PTR_WIDTH:0] zero-extended to AXIS_WIDTH.
  - N==0 or N > 2^REFMEM_PTR_WIDTH - PAD_WORDS: set err[0], go to DRAIN. If that header beat had tlast, go to IDLE instead.
  - Otherwise latch ref_len=N and go to CMD.
  - Header with tlast and legal N: set err[1], go to CMD; all N words are then padded.
- CMD:
  - tready=0.
  - Wait while mem_busy=1.
  - When mem_busy=0, assert load_cmd for exactly one cycle, then go to WAIT_CLR.
- WAIT_CLR:
  - Wait until fifo_clear=0, then go to STREAM.
  - No FIFO write is ever issued while fifo_clear=1.
- STREAM:
  - tready = !fifo_full.
  - fifo_wr_en = tvalid & tready; fifo_din = tdata; sample counter increments per write.
  - fifo_full=1 stalls with tready=0, no write, no data loss.
  - tlast on write k<N: set err[1]; the remaining N-k words are written as zeros in PAD before the PAD_WORDS pad.
  - Write N without tlast: set err[2], go to PAD, then DRAIN.
  - Write N with tlast: go to PAD.
- PAD:
  - tready=0.
  - Writes zeros while !fifo_full until (N - written samples) + PAD_WORDS words are done.
  - Then DONE, or DRAIN if the frame was long.
- DRAIN:
  - tready=1; discard beats, no FIFO writes.
  - On accepted tlast go to DONE (bad-length path goes to IDLE).
- DONE:
  - Wait for ref_load_done=1, then go to IDLE and clear the counters.
- Total FIFO writes per legal frame = N + PAD_WORDS exactly.
- Widths: the sample counter is REFMEM_PTR_WIDTH+1 bits, so N at the maximum does not wrap.
- err_flags clear only on rst.

Optional Feature:
- Macro: REF_LOADER_STATS_EN.
- When defined, adds outputs:
  - stat_frames (32): increments on each DONE->IDLE transition.
  - stat_words (32): increments on each sample write, pads excluded.
  - Both wrap at 2^32 and reset to 0.
- When undefined, neither the ports nor the logic exist.

Test Plan:
- Header 5 then samples 1..5, tlast on beat 5, mem_busy=0, fifo_clear drops 2 cycles after load_cmd:
  - one load_cmd pulse, ref_len=5.
  - FIFO receives 1,2,3,4,5,0,0 (7 writes); no write while fifo_clear=1.
  - ref_load_done=1 -> IDLE; err_flags=0.
- Header 4, mem_busy=1 for 10 cycles:
  - load_cmd only after mem_busy falls; tready=0 throughout the wait.
- Header 6, tlast on sample 3:
  - FIFO gets 3 samples + 3 zeros + 2 pads = 8 writes; err[1]=1.
- Header 2, 4 sample beats, tlast on 4th:
  - writes s1,s2,0,0; beats 3-4 discarded; err[2]=1.
- Header 0 followed by a 3-beat frame ending in tlast:
  - err[0]=1; no load_cmd; no FIFO writes; next valid frame loads normally.
- Header 3, fifo_full held 4 cycles mid-stream:
  - tready=0 while full; all 3 samples written in order; 5 total writes.
